// File: rtl/tenv_ssram_arb.sv
// Two-requester arbiter in front of one single-port synchronous SRAM.
// Define TENV_SSRAM_ARB_FIXED_PRI_EN for fixed A-over-B priority instead of round-robin.
module tenv_ssram_arb #(
  parameter int WADDR = 10,
  parameter int WDATA = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic             a_wr,
  input  logic [WADDR-1:0] a_addr,
  input  logic [WDATA-1:0] a_wdata,
  output logic             a_gnt,
  output logic             a_rvalid,
  output logic [WDATA-1:0] a_rdata,
  input  logic             b_req,
  input  logic             b_wr,
  input  logic [WADDR-1:0] b_addr,
  input  logic [WDATA-1:0] b_wdata,
  output logic             b_gnt,
  output logic             b_rvalid,
  output logic [WDATA-1:0] b_rdata,
  output logic             mem_wr,
  output logic [WADDR-1:0] mem_addr,
  output logic [WDATA-1:0] mem_datain,
  input  logic [WDATA-1:0] mem_dataout
);

  // state | meaning
  // PRI_A | A wins when both request
  // PRI_B | B wins when both request
  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

  logic iss_rd_a, iss_rd_b;
  logic ret_rd_a, ret_rd_b;

`ifdef TENV_SSRAM_ARB_FIXED_PRI_EN
  assign a_gnt = a_req;
  assign b_gnt = b_req & ~a_req;
`else
  pri_t pri_q, pri_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pri_q <= PRI_A;
    else        pri_q <= pri_d;
  end

  // Pointer hands priority to the other side after every grant.
  always_comb begin
    pri_d = pri_q;
    if (a_gnt)      pri_d = PRI_B;
    else if (b_gnt) pri_d = PRI_A;
  end

  assign a_gnt = a_req & (~b_req | (pri_q == PRI_A));
  assign b_gnt = b_req & (~a_req | (pri_q == PRI_B));
`endif

  // Issue stage: winner goes straight onto the memory port; idle keeps addr/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_datain <= '0;
      iss_rd_a   <= 1'b0;
      iss_rd_b   <= 1'b0;
    end else if (a_gnt) begin
      mem_wr     <= a_wr;
      mem_addr   <= a_addr;
      mem_datain <= a_wdata;
      iss_rd_a   <= ~a_wr;
      iss_rd_b   <= 1'b0;
    end else if (b_gnt) begin
      mem_wr     <= b_wr;
      mem_addr   <= b_addr;
      mem_datain <= b_wdata;
      iss_rd_a   <= 1'b0;
      iss_rd_b   <= ~b_wr;
    end else begin
      mem_wr     <= 1'b0;
      iss_rd_a   <= 1'b0;
      iss_rd_b   <= 1'b0;
    end
  end

  // Tag follows the read through the memory's one-cycle sampling delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_rd_a <= 1'b0;
      ret_rd_b <= 1'b0;
    end else begin
      ret_rd_a <= iss_rd_a;
      ret_rd_b <= iss_rd_b;
    end
  end

  assign a_rvalid = ret_rd_a;
  assign b_rvalid = ret_rd_b;
  assign a_rdata  = mem_dataout;
  assign b_rdata  = mem_dataout;

endmodule

// File: tb/tb_tenv_ssram_arb.sv
// Randomized and directed bench for tenv_ssram_arb against a transaction-level model.
module tb_tenv_ssram_arb;

  logic       clk;
  logic       rst_n;
  logic       a_req, a_wr, b_req, b_wr;
  logic [9:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       mem_wr;
  logic [9:0] mem_addr;
  logic [7:0] mem_datain;
  logic [7:0] mem_dataout;

  tenv_ssram_arb #(.WADDR(10), .WDATA(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  // SRAM: registered read, a write cycle leaves read data alone.
  logic [7:0] sram [1024];
  logic       loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) sram[i] <= init_val(i);
      loaded <= 1'b1;
    end else if (mem_wr) sram[mem_addr] <= mem_datain;
    else                 mem_dataout <= sram[mem_addr];
  end

  // Reference model: expected contents, priority owner, outstanding reads.
  typedef struct { int unsigned due; logic own_b; logic [7:0] data; } rd_t;
  rd_t         rq[$];
  logic [7:0]  shadow [1024];
  logic        m_ptr_b;
  logic        x_wr;
  logic [9:0]  x_addr;
  logic [7:0]  x_din;
  logic        g_a, g_b;
  int unsigned cyc;
  int          n_tests, n_fail;
  int          n_ga, n_rva, n_rvb;
  logic [7:0]  last_a, last_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    rq.delete();
    m_ptr_b = 1'b0;
    x_wr = 1'b0;
    x_addr = '0;
    x_din = '0;
  endtask

  // Entered at posedge+1; drives one cycle, checks at negedge, returns at next posedge+1.
  task automatic cyc_step(input logic ar, input logic aw, input logic [9:0] aa, input logic [7:0] ad,
                          input logic br, input logic bw, input logic [9:0] ba, input logic [7:0] bd);
    logic ea, eb, xa, xb;
    logic [7:0] rd;
    a_req = ar; a_wr = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_wr = bw; b_addr = ba; b_wdata = bd;
    @(negedge clk);
`ifdef TENV_SSRAM_ARB_FIXED_PRI_EN
    ea = ar;
    eb = br && !ar;
`else
    ea = ar && (!br || !m_ptr_b);
    eb = br && (!ar || m_ptr_b);
`endif
    chk("a_gnt", 32'(a_gnt), 32'(ea));
    chk("b_gnt", 32'(b_gnt), 32'(eb));
    chk("mem_wr", 32'(mem_wr), 32'(x_wr));
    chk("mem_addr", 32'(mem_addr), 32'(x_addr));
    chk("mem_datain", 32'(mem_datain), 32'(x_din));
    xa = 1'b0; xb = 1'b0; rd = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].own_b) xb = 1'b1; else xa = 1'b1;
      rd = rq[0].data;
      void'(rq.pop_front());
    end
    chk("a_rvalid", 32'(a_rvalid), 32'(xa));
    chk("b_rvalid", 32'(b_rvalid), 32'(xb));
    if (xa) chk("a_rdata", 32'(a_rdata), 32'(rd));
    if (xb) chk("b_rdata", 32'(b_rdata), 32'(rd));
    if (a_rvalid) begin n_rva++; last_a = a_rdata; end
    if (b_rvalid) begin n_rvb++; last_b = b_rdata; end
    if (ea) begin
      x_wr = aw; x_addr = aa; x_din = ad;
      if (aw) shadow[aa] = ad;
      else    rq.push_back('{cyc + 2, 1'b0, shadow[aa]});
      m_ptr_b = 1'b1;
      n_ga++;
    end else if (eb) begin
      x_wr = bw; x_addr = ba; x_din = bd;
      if (bw) shadow[ba] = bd;
      else    rq.push_back('{cyc + 2, 1'b1, shadow[ba]});
      m_ptr_b = 1'b0;
    end else x_wr = 1'b0;
    g_a = ea;
    g_b = eb;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    a_req = 1'b0; b_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_datain", 32'(mem_datain), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_hold_mem_wr", 32'(mem_wr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_clear();
  endtask

  logic       pr_a, pw_a, pr_b, pw_b;
  logic [9:0] pa_a, pa_b;
  logic [7:0] pd_a, pd_b;

  task automatic new_a();
    pr_a = ($urandom_range(0, 3) != 0);
    pw_a = ($urandom_range(0, 2) == 0);
    pa_a = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom);
    pd_a = 8'($urandom);
  endtask

  task automatic new_b();
    pr_b = ($urandom_range(0, 3) != 0);
    pw_b = ($urandom_range(0, 1) == 0);
    pa_b = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom);
    pd_b = 8'($urandom);
  endtask

  int base_ga, base_rva, base_rvb;

  initial begin
    n_tests = 0; n_fail = 0; n_ga = 0; n_rva = 0; n_rvb = 0; cyc = 0;
    last_a = '0; last_b = '0; g_a = 1'b0; g_b = 1'b0;
    a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    model_clear();
    rst_n = 1'b1;
    #3;
    do_reset(3);

    // A writes 0x5A to 0x003, then reads it back.
    cyc_step(1, 1, 10'h003, 8'h5A, 0, 0, '0, '0);
    chk("wr_gnt", 32'(g_a), 32'd1);
    idle(1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h003);
    base_rvb = n_rvb;
    cyc_step(1, 0, 10'h003, 8'h00, 0, 0, '0, '0);
    idle(3);
    chk("rd_5a_data", 32'(last_a), 32'h5A);
    chk("rd_5a_no_b", 32'(n_rvb - base_rvb), 32'd0);

    // Both read continuously from reset.
    do_reset(2);
    base_ga = n_ga; base_rva = n_rva; base_rvb = n_rvb;
    for (int i = 0; i < 8; i++) cyc_step(1, 0, 10'h010, 8'h00, 1, 0, 10'h020, 8'h00);
    idle(3);
`ifdef TENV_SSRAM_ARB_FIXED_PRI_EN
    chk("both_a_grants", 32'(n_ga - base_ga), 32'd8);
    chk("both_b_rvalids", 32'(n_rvb - base_rvb), 32'd0);
`else
    chk("both_a_grants", 32'(n_ga - base_ga), 32'd4);
    chk("both_b_rvalids", 32'(n_rvb - base_rvb), 32'd4);
    chk("both_b_data", 32'(last_b), 32'(init_val(32)));
`endif
    chk("both_a_data", 32'(last_a), 32'(init_val(16)));

    // B write then A read of the same address in the next cycle.
    cyc_step(0, 0, '0, '0, 1, 1, 10'h100, 8'h77);
    cyc_step(1, 0, 10'h100, 8'h00, 0, 0, '0, '0);
    idle(3);
    chk("raw_data", 32'(last_a), 32'h77);

    // Reset the cycle after a read grant: the read must vanish.
    cyc_step(1, 0, 10'h003, 8'h00, 0, 0, '0, '0);
    base_rva = n_rva;
    do_reset(2);
    idle(4);
    chk("rst_drop_rvalid", 32'(n_rva - base_rva), 32'd0);

    idle(5);

    new_a(); new_b();
    for (int i = 0; i < 1500; i++) begin
      cyc_step(pr_a, pw_a, pa_a, pd_a, pr_b, pw_b, pa_b, pd_b);
      if (g_a || !pr_a || $urandom_range(0, 7) == 0) new_a();
      if (g_b || !pr_b || $urandom_range(0, 7) == 0) new_b();
    end
    idle(4);
    chk("drain_empty", 32'(rq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tenv_ssram_arb.md
Name: tenv_ssram_arb

Overview:
- Two-requester arbiter for one single-port synchronous SRAM (registered read data; a write cycle does not update read data).
- Requester A is the instruction-fetch side and requester B is the load/store side of the core testbench; both share one memory array.
- Each requester uses a req/gnt handshake. The arbiter registers the winning access onto the memory port and returns read data with a fixed latency and a per-requester valid.

Parameters:
- WADDR, 10, memory address width.
- WDATA, 8, memory data width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a_req  in  1  A access request; held with a_wr/a_addr/a_wdata stable until a_gnt.
- a_wr  in  1  A access type: 1 = write, 0 = read.
- a_addr  in  WADDR  A address.
- a_wdata  in  WDATA  A write data.
- a_gnt  out  1  A request accepted this cycle (combinational).
- a_rvalid  out  1  a_rdata holds A read result this cycle.
- a_rdata  out  WDATA  A read data.
- b_req, b_wr, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- mem_wr  out  1  memory write enable (registered).
- mem_addr  out  WADDR  memory address (registered).
- mem_datain  out  WDATA  memory write data (registered).
- mem_dataout  in  WDATA  memory read data; valid the cycle after a read is presented.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - mem_wr=0, mem_addr=0, mem_datain=0.
  - a_rvalid=b_rvalid=0.
  - Pipeline tags cleared.
  - Priority pointer set to A.
- Grants are combinational: at most one of a_gnt/b_gnt is high per cycle, and gnt implies the matching req.
- Only one requester has req high: that requester is granted.
- Both have req high: the pointer owner is granted. After any grant the pointer moves to the other requester (round-robin).
- No req: no grant. The pointer is unchanged. The next cycle has mem_wr=0 and holds mem_addr/mem_datain.
- A request is consumed at the rising edge ending its gnt cycle T. A requester may present its next request in cycle T+1.
- Issue stage, on the edge ending T:
  - mem_wr <= winner wr; mem_addr <= winner addr; mem_datain <= winner wdata.
  - Issue tag <= {read, owner} for a granted read; otherwise tag <= none.
- Memory stage: the memory samples at the edge ending T+1. The tag moves to the return stage.
- Return stage, cycle T+2:
  - The owner's rvalid=1 for exactly one cycle.
  - a_rdata = b_rdata = mem_dataout at all times (pass-through); the data is meaningful only while rvalid is high.
- Read latency is 2 cycles from gnt. Writes produce no response.
- Throughput is one access per cycle aggregate, so back-to-back grants are legal.
- Read-after-write to the same address granted in consecutive cycles returns the new data, because memory order equals grant order.
- rst_n asserted mid-operation: in-flight reads are discarded (no rvalid) and the pointer returns to A. After rst_n is released, the first grant follows the normal rules.
- A requester dropping req before gnt is legal. No access is issued and there is no side effect.

Optional Feature:
- Macro: TENV_SSRAM_ARB_FIXED_PRI_EN.
- Defined: fixed priority. A always wins when both requests are high, and the pointer register is not implemented.
- Undefined: round-robin as in Behaviour.

Test Plan:
- Reset, then A writes 0x5A to addr 0x003: a_gnt in the same cycle; next cycle mem_wr=1, mem_addr=0x003, mem_datain=0x5A; no rvalid anywhere.
- Read of 0x003 by A after that write: a_rvalid high exactly 2 cycles after a_gnt with a_rdata=0x5A; b_rvalid stays 0.
- A and B both request reads continuously from reset (A addr 0x010, B addr 0x020): grants alternate A,B,A,B. Each rvalid follows its gnt by 2 cycles, and the data matches preloaded memory contents. With TENV_SSRAM_ARB_FIXED_PRI_EN, only A is granted while a_req=1.
- B writes 0x77 to 0x100, then A reads 0x100 in the very next cycle: the A read returns 0x77.
- A read granted, then rst_n pulsed low the cycle after gnt: no a_rvalid is ever produced; all mem_* outputs are 0 during reset.
- Idle cycles (no req): mem_wr=0, no gnt, and no rvalid for 5 consecutive cycles.
